// File: rtl/dmem_resp.sv
// dmem_resp: RV32I data-memory responder with programmable latency; define DMEM_MISALIGN_CHECK_EN to fault misaligned/illegal accesses
module dmem_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = $clog2(LATENCY + 1);
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q;
   logic [AW+1:0]   addr_q;
   logic [2:0]      f3_q;
   logic [31:0]     wdata_q;
   logic [31:0]     rdata_q;
   logic            err_q;
   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [AW-1:0]   idx;
   logic [1:0]      lane;
   logic [31:0]     word;
   logic            is_b, is_h, fault, accept, do_access;
   logic [7:0]      ld_b;
   logic [15:0]     ld_h;
   logic [3:0]      mask;
   logic [31:0]     bmask, st_data, st_word, ld_data;
   logic            unused_addr;

   assign unused_addr = ^req_addr[31:AW+2];
   assign idx       = addr_q[AW+1:2];
   assign lane      = addr_q[1:0];
   assign word      = mem_q[idx];
   assign is_b      = f3_q[1:0] == 2'b00;
   assign is_h      = f3_q[1:0] == 2'b01;
   assign accept    = state_q == IDLE && req_valid;
   assign do_access = state_q == BUSY && cnt_q == '0;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign fault = (is_h && lane[0]) || (f3_q == 3'b010 && lane != 2'b00) || f3_q == 3'b011 ||
                  f3_q[2:1] == 2'b11 || (we_q && f3_q[2]);
`else
   assign fault = 1'b0;
`endif

   // Lane extraction and extension for loads; read-modify-write merge for stores
   always_comb begin
      ld_b    = 8'(word >> {lane, 3'b000});
      ld_h    = lane[1] ? word[31:16] : word[15:0];
      ld_data = is_b ? {{24{~f3_q[2] & ld_b[7]}}, ld_b} :
                is_h ? {{16{~f3_q[2] & ld_h[15]}}, ld_h} : word;
      mask    = is_b ? 4'b0001 << lane : is_h ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      st_data = is_b ? {4{wdata_q[7:0]}} : is_h ? {2{wdata_q[15:0]}} : wdata_q;
      bmask   = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
      st_word = (word & ~bmask) | (st_data & bmask);
   end

   // Next-state logic: accept in IDLE, count down in BUSY, wait for handshake in RESP
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = BUSY;
         cnt_d   = CNT_INIT;
      end else if (state_q == BUSY) begin
         state_d = cnt_q == '0 ? RESP : BUSY;
         cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
         state_d = IDLE;
      end
   end

   // State, counter and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (do_access) begin
            rdata_q <= (we_q || fault) ? 32'h0 : ld_data;
            err_q   <= fault;
         end
      end
   end

   // Request capture; only meaningful after an accept so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr[AW+1:0];
         f3_q    <= req_funct3;
         wdata_q <= req_wdata;
      end
   end

   // RAM write lands on the same edge the response becomes valid
   always_ff @(posedge clk) begin
      if (!rst && do_access && we_q && !fault) mem_q[idx] <= st_word;
   end

   assign req_ready = state_q == IDLE && !rst;
   assign rsp_valid = state_q == RESP;
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: scoreboard bench for dmem_resp with directed load/store vectors
module tb_dmem_resp;
   localparam int DW = 1024;
   localparam int L  = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_chk = 0;
   int n_fail = 0;
   logic [32:0] sb_q[$];

   dmem_resp #(.DEPTH_WORDS(DW), .LATENCY(L)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every response handshake is matched against the oldest expectation
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
         end else begin
            logic [32:0] e;
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e[31:0]);
            chk("rsp_err", 32'(rsp_err), 32'(e[32]));
         end
      end
   end

   task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'h1);
      req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 1;
      forever begin
         @(posedge clk);
         #1;
         if (rsp_valid || n >= 20) break;
         n++;
      end
      if (!rsp_valid) chk("rsp_timeout", 32'(rsp_valid), 32'h1);
   endtask

   task automatic txn(input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] er, input logic ee);
      int n;
      sb_q.push_back({ee, er});
      issue(we, a, f3, wd);
      wait_valid(n);
      chk("latency", 32'(n), 32'(L));
      @(posedge clk);
      #1;
      chk("req_ready_after_hs", 32'(req_ready), 32'h1);
      chk("rsp_valid_after_hs", 32'(rsp_valid), 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [31:0] base;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk);
      #1 chk("req_ready_post_rst", 32'(req_ready), 32'h1);

      txn(1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 0);
      txn(0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 0);
      txn(1, 32'h13, 3'b000, 32'h00000080, 32'h0, 0);
      txn(0, 32'h10, 3'b010, 32'h0, 32'h80ADBEEF, 0);
      txn(0, 32'h13, 3'b000, 32'h0, 32'hFFFFFF80, 0);
      txn(0, 32'h13, 3'b100, 32'h0, 32'h00000080, 0);
      txn(1, 32'h12, 3'b001, 32'hFFFF1234, 32'h0, 0);
      txn(0, 32'h10, 3'b010, 32'h0, 32'h1234BEEF, 0);
      txn(0, 32'h12, 3'b001, 32'h0, 32'h00001234, 0);
      txn(0, 32'h10, 3'b101, 32'h0, 32'h0000BEEF, 0);
      txn(0, 32'h10, 3'b001, 32'h0, 32'hFFFFBEEF, 0);
      txn(0, 32'h11, 3'b000, 32'h0, 32'hFFFFFFBE, 0);
      txn(0, 32'h12, 3'b100, 32'h0, 32'h00000034, 0);

      // Stalled response: outputs hold, no second accept
      sb_q.push_back({1'b0, 32'h1234BEEF});
      rsp_ready = 1'b0;
      issue(0, 32'h10, 3'b010, 32'h0);
      wait_valid(n);
      chk("stall_latency", 32'(n), 32'(L));
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_funct3 = 3'b010; req_wdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("stall_rsp_valid", 32'(rsp_valid), 32'h1);
         chk("stall_rsp_rdata", rsp_rdata, 32'h1234BEEF);
         chk("stall_req_ready", 32'(req_ready), 32'h0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_req_ready_after", 32'(req_ready), 32'h1);
      repeat (4) @(posedge clk);
      #1 chk("no_second_accept", 32'(rsp_valid), 32'h0);
      txn(0, 32'h10, 3'b010, 32'h0, 32'h1234BEEF, 0);

`ifdef DMEM_MISALIGN_CHECK_EN
      txn(0, 32'h11, 3'b010, 32'h0, 32'h0, 1);
      txn(1, 32'h12, 3'b010, 32'hCAFEF00D, 32'h0, 1);
      txn(0, 32'h10, 3'b010, 32'h0, 32'h1234BEEF, 0);
      txn(0, 32'h10, 3'b011, 32'h0, 32'h0, 1);
      txn(0, 32'h13, 3'b001, 32'h0, 32'h0, 1);
      txn(1, 32'h10, 3'b100, 32'h0, 32'h0, 1);
      txn(0, 32'h10, 3'b010, 32'h0, 32'h1234BEEF, 0);
`else
      txn(0, 32'h11, 3'b010, 32'h0, 32'h1234BEEF, 0);
      txn(1, 32'h12, 3'b010, 32'hCAFEF00D, 32'h0, 0);
      txn(0, 32'h10, 3'b010, 32'h0, 32'hCAFEF00D, 0);
      txn(0, 32'h10, 3'b011, 32'h0, 32'hCAFEF00D, 0);
      txn(0, 32'h13, 3'b001, 32'h0, 32'hFFFFCAFE, 0);
`endif

      // Aliasing and reset mid-operation
      base = 32'(DW * 4);
      txn(1, 32'h20, 3'b010, 32'h11223344, 32'h0, 0);
      txn(0, base + 32'h20, 3'b010, 32'h0, 32'h11223344, 0);
      issue(1, 32'h20, 3'b010, 32'h55667788);
      rst = 1'b1;
      @(posedge clk);
      #1 chk("midrst_req_ready", 32'(req_ready), 32'h0);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1 chk("midrst_no_rsp", 32'(rsp_valid), 32'h0);
      end
      chk("midrst_rdata", rsp_rdata, 32'h0);
      chk("midrst_req_ready_after", 32'(req_ready), 32'h1);
      txn(0, 32'h20, 3'b010, 32'h0, 32'h11223344, 0);
      txn(1, base + 32'h20, 3'b000, 32'h000000AA, 32'h0, 0);
      txn(0, 32'h20, 3'b010, 32'h0, 32'h112233AA, 0);

      // Reset while a response is pending drops it
      rsp_ready = 1'b0;
      issue(0, 32'h20, 3'b010, 32'h0);
      wait_valid(n);
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      chk("drop_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("drop_rsp_rdata", rsp_rdata, 32'h0);
      @(negedge clk) begin rst = 1'b0; rsp_ready = 1'b1; end
      @(posedge clk);
      #1 chk("drop_req_ready", 32'(req_ready), 32'h1);

      repeat (3) @(posedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
